// File: rtl/dsp_macc_sequencer.sv
// Purpose : streaming dot-product front end for the RS_DSP2 multiply-accumulate macro.
// Latency : result presented DSP_LAT+1 cycles after the closing operand beat handshake.
// Backpr. : in_ready low from the closing beat until the result is taken (one vector in flight).
//
// Ports:
//   clk, reset                 single clock, synchronous active-high reset
//   in_valid/in_ready          operand stream: in_a (20b), in_b (18b), in_last
//   cfg_unsigned_a/_b, cfg_subtract  per-vector mode, sampled on the first beat only
//   dsp_a, dsp_b, dsp_load_acc, dsp_feedback, dsp_unsigned_a/_b, dsp_subtract  MACC controls
//   dsp_z                      MACC accumulator output
//   out_valid/out_ready        result stream: out_data (38b), out_len, out_trunc
// Build option: define DSP_MACC_SEQ_SAT_EN to add out_sat and dsp_saturate.
module dsp_macc_sequencer #(
  parameter int DSP_LAT = 1,
  parameter int MAX_LEN = 1024,
  parameter int LEN_W   = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [19:0]      in_a,
  input  logic [17:0]      in_b,
  input  logic             in_last,
  input  logic             cfg_unsigned_a,
  input  logic             cfg_unsigned_b,
  input  logic             cfg_subtract,
  output logic [19:0]      dsp_a,
  output logic [17:0]      dsp_b,
  output logic             dsp_load_acc,
  output logic [2:0]       dsp_feedback,
  output logic             dsp_unsigned_a,
  output logic             dsp_unsigned_b,
  output logic             dsp_subtract,
`ifdef DSP_MACC_SEQ_SAT_EN
  output logic             dsp_saturate,
  output logic             out_sat,
`endif
  input  logic [37:0]      dsp_z,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [37:0]      out_data,
  output logic [LEN_W-1:0] out_len,
  output logic             out_trunc
);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DRAIN, S_HOLD} state_t;

  localparam int                DW         = (DSP_LAT < 1) ? 1 : $clog2(DSP_LAT + 1);
  localparam logic [LEN_W-1:0]  LEN_MAX    = LEN_W'(MAX_LEN);
  localparam logic [DW-1:0]     DRAIN_LAST = DW'(DSP_LAT);

  state_t           r_state, w_state_nxt;
  logic [19:0]      r_dsp_a, w_dsp_a_nxt;
  logic [17:0]      r_dsp_b, w_dsp_b_nxt;
  logic             r_load, w_load_nxt;
  logic             r_ua, w_ua_nxt;
  logic             r_ub, w_ub_nxt;
  logic             r_sub, w_sub_nxt;
  logic [LEN_W-1:0] r_count, w_count_nxt;
  logic             r_trunc, w_trunc_nxt;
  logic [DW-1:0]    r_drain, w_drain_nxt;
  logic             r_out_valid, w_out_valid_nxt;
  logic [37:0]      r_out_data;

  logic             w_in_ready;
  logic             w_accept;
  logic [LEN_W-1:0] w_cnt_inc;
  logic             w_at_max;
  logic             w_capture;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_dsp_a     <= '0;
      r_dsp_b     <= '0;
      r_load      <= 1'b0;
      r_ua        <= 1'b0;
      r_ub        <= 1'b0;
      r_sub       <= 1'b0;
      r_count     <= '0;
      r_trunc     <= 1'b0;
      r_drain     <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_dsp_a     <= w_dsp_a_nxt;
      r_dsp_b     <= w_dsp_b_nxt;
      r_load      <= w_load_nxt;
      r_ua        <= w_ua_nxt;
      r_ub        <= w_ub_nxt;
      r_sub       <= w_sub_nxt;
      r_count     <= w_count_nxt;
      r_trunc     <= w_trunc_nxt;
      r_drain     <= w_drain_nxt;
      r_out_valid <= w_out_valid_nxt;
      if (w_capture) begin
        r_out_data <= dsp_z;
      end
    end
  end

  always_comb begin
    w_in_ready = (r_state == S_IDLE) || (r_state == S_ACCUM);
    w_accept   = in_valid && w_in_ready;
    // First beat of a vector counts as 1; later beats extend the running count.
    w_cnt_inc  = (r_state == S_IDLE) ? LEN_W'(1) : (r_count + LEN_W'(1));
    w_at_max   = (w_cnt_inc == LEN_MAX);

    // Defaults: no beat means zero operands while keeping the accumulator.
    w_state_nxt     = r_state;
    w_dsp_a_nxt     = '0;
    w_dsp_b_nxt     = '0;
    w_load_nxt      = 1'b1;
    w_ua_nxt        = r_ua;
    w_ub_nxt        = r_ub;
    w_sub_nxt       = r_sub;
    w_count_nxt     = r_count;
    w_trunc_nxt     = r_trunc;
    w_drain_nxt     = r_drain;
    w_out_valid_nxt = r_out_valid;
    w_capture       = 1'b0;

    case (r_state)
      S_IDLE, S_ACCUM: begin
        if (w_accept) begin
          w_dsp_a_nxt = in_a;
          w_dsp_b_nxt = in_b;
          // The first beat loads the product alone, clearing the previous vector.
          w_load_nxt  = (r_state == S_ACCUM);
          w_count_nxt = w_cnt_inc;
          // A vector that reaches the length cap on its real last beat is not truncated.
          w_trunc_nxt = w_at_max && !in_last;
          w_drain_nxt = '0;
          w_state_nxt = (in_last || w_at_max) ? S_DRAIN : S_ACCUM;
          if (r_state == S_IDLE) begin
            w_ua_nxt  = cfg_unsigned_a;
            w_ub_nxt  = cfg_unsigned_b;
            w_sub_nxt = cfg_subtract;
          end
        end
      end
      S_DRAIN: begin
        // The closing product reaches dsp_z DSP_LAT edges after it was registered.
        if (r_drain == DRAIN_LAST) begin
          w_capture       = 1'b1;
          w_out_valid_nxt = 1'b1;
          w_state_nxt     = S_HOLD;
        end else begin
          w_drain_nxt = r_drain + DW'(1);
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          w_out_valid_nxt = 1'b0;
          w_state_nxt     = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // in_ready is forced low while reset is held so every output reads 0 in reset.
  assign in_ready       = w_in_ready && !reset;
  assign dsp_a          = r_dsp_a;
  assign dsp_b          = r_dsp_b;
  assign dsp_load_acc   = r_load;
  assign dsp_feedback   = 3'b000;
  assign dsp_unsigned_a = r_ua;
  assign dsp_unsigned_b = r_ub;
  assign dsp_subtract   = r_sub;
  assign out_valid      = r_out_valid;
  assign out_data       = r_out_data;
  assign out_len        = r_count;
  assign out_trunc      = r_trunc;

`ifdef DSP_MACC_SEQ_SAT_EN
  logic r_out_sat;
  logic r_saturate;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_sat  <= 1'b0;
      r_saturate <= 1'b0;
    end else begin
      r_saturate <= 1'b1;
      if (w_capture) begin
        // Saturated MACC results sit at the positive or negative 38-bit rail.
        r_out_sat <= (dsp_z == 38'h1F_FFFF_FFFF) || (dsp_z == 38'h20_0000_0000);
      end
    end
  end

  assign out_sat      = r_out_sat;
  assign dsp_saturate = r_saturate;
`endif

endmodule

// File: tb/tb_dsp_macc_sequencer.sv
module tb_dsp_macc_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        m_in_valid, s_in_valid;
  logic        m_in_ready, s_in_ready;
  logic [19:0] in_a;
  logic [17:0] in_b;
  logic        in_last, cfg_ua, cfg_ub, cfg_sub, out_ready;
  logic [19:0] m_dsp_a, s_dsp_a;
  logic [17:0] m_dsp_b, s_dsp_b;
  logic        m_load, s_load;
  logic [2:0]  m_fb, s_fb;
  logic        m_ua, m_ub, m_sub, s_ua, s_ub, s_sub;
  logic [37:0] z_m = '0;
  logic [37:0] z_s = '0;
  logic        m_out_valid, s_out_valid;
  logic [37:0] m_out_data, s_out_data;
  logic [10:0] m_out_len;
  logic [2:0]  s_out_len;
  logic        m_out_trunc, s_out_trunc;
`ifdef DSP_MACC_SEQ_SAT_EN
  logic        m_sat_en, s_sat_en, m_out_sat, s_out_sat;
`endif

  dsp_macc_sequencer #(.DSP_LAT(1), .MAX_LEN(1024), .LEN_W(11)) u_dut (
    .clk(clk), .reset(reset), .in_valid(m_in_valid), .in_ready(m_in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .cfg_unsigned_a(cfg_ua), .cfg_unsigned_b(cfg_ub), .cfg_subtract(cfg_sub),
    .dsp_a(m_dsp_a), .dsp_b(m_dsp_b), .dsp_load_acc(m_load), .dsp_feedback(m_fb),
    .dsp_unsigned_a(m_ua), .dsp_unsigned_b(m_ub), .dsp_subtract(m_sub),
`ifdef DSP_MACC_SEQ_SAT_EN
    .dsp_saturate(m_sat_en), .out_sat(m_out_sat),
`endif
    .dsp_z(z_m), .out_valid(m_out_valid), .out_ready(out_ready),
    .out_data(m_out_data), .out_len(m_out_len), .out_trunc(m_out_trunc)
  );

  dsp_macc_sequencer #(.DSP_LAT(1), .MAX_LEN(4), .LEN_W(3)) u_dut4 (
    .clk(clk), .reset(reset), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .cfg_unsigned_a(cfg_ua), .cfg_unsigned_b(cfg_ub), .cfg_subtract(cfg_sub),
    .dsp_a(s_dsp_a), .dsp_b(s_dsp_b), .dsp_load_acc(s_load), .dsp_feedback(s_fb),
    .dsp_unsigned_a(s_ua), .dsp_unsigned_b(s_ub), .dsp_subtract(s_sub),
`ifdef DSP_MACC_SEQ_SAT_EN
    .dsp_saturate(s_sat_en), .out_sat(s_out_sat),
`endif
    .dsp_z(z_s), .out_valid(s_out_valid), .out_ready(out_ready),
    .out_data(s_out_data), .out_len(s_out_len), .out_trunc(s_out_trunc)
  );

  // MACC macro model, latency 1: z updates from the registered operands each edge.
  function automatic logic [37:0] macc_step(input logic [37:0] z, input logic [19:0] a,
                                            input logic [17:0] b, input logic ld,
                                            input logic ua, input logic ub, input logic sub);
    logic [63:0] ae, be, p, acc;
    ae  = ua ? {44'd0, a} : {{44{a[19]}}, a};
    be  = ub ? {46'd0, b} : {{46{b[17]}}, b};
    p   = ae * be;
    acc = ld ? {26'd0, z} : 64'd0;
    acc = sub ? (acc - p) : (acc + p);
    return acc[37:0];
  endfunction

  always @(posedge clk) begin
    z_m <= macc_step(z_m, m_dsp_a, m_dsp_b, m_load, m_ua, m_ub, m_sub);
    z_s <= macc_step(z_s, s_dsp_a, s_dsp_b, s_load, s_ua, s_ub, s_sub);
  end

  int nchk = 0;
  int nerr = 0;

  logic [19:0] va [16];
  logic [17:0] vb [16];

  // Reference: plain dot product of the vector with first-beat signedness.
  function automatic logic [37:0] ref_dot(input int n, input logic ua, input logic ub,
                                          input logic sub);
    logic [63:0] sum, ae, be;
    sum = '0;
    for (int i = 0; i < n; i++) begin
      ae  = ua ? {44'd0, va[i]} : {{44{va[i][19]}}, va[i]};
      be  = ub ? {46'd0, vb[i]} : {{46{vb[i][17]}}, vb[i]};
      sum = sum + ae * be;
    end
    if (sub) sum = -sum;
    return sum[37:0];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic send_beat(input int sel, input logic [19:0] a, input logic [17:0] b,
                           input logic last, input logic ua, input logic ub, input logic sub);
    int   waitc;
    logic rdy;
    in_a = a; in_b = b; in_last = last;
    cfg_ua = ua; cfg_ub = ub; cfg_sub = sub;
    if (sel == 0) m_in_valid = 1'b1; else s_in_valid = 1'b1;
    waitc = 0;
    rdy   = 1'b0;
    while (!rdy && waitc < 200) begin
      rdy = (sel == 0) ? m_in_ready : s_in_ready;
      @(posedge clk); #1;
      waitc++;
    end
    m_in_valid = 1'b0;
    s_in_valid = 1'b0;
    check("beat_accept", rdy, 1);
  endtask

  task automatic bubbles(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); @(negedge clk);
      check("bubble.dsp_a", m_dsp_a, 0);
      check("bubble.dsp_b", m_dsp_b, 0);
      check("bubble.load_acc", m_load, 1);
    end
  endtask

  task automatic wait_valid(input int sel, output int lat);
    lat = 0;
    while (!((sel == 0) ? m_out_valid : s_out_valid) && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_vec(input int sel, input int n, input logic close_last,
                         input logic ua, input logic ub, input logic sub,
                         input int bub_at, input int nbub, input logic [37:0] exp_data,
                         input int exp_len, input logic exp_trunc, input string name);
    int lat;
    for (int i = 0; i < n; i++) begin
      // Later beats carry inverted cfg: it must be ignored after the first beat.
      send_beat(sel, va[i], vb[i], close_last && (i == n - 1),
                (i == 0) ? ua : ~ua, (i == 0) ? ub : ~ub, (i == 0) ? sub : ~sub);
      if (sel == 0) begin
        check({name, ".dsp_a"}, m_dsp_a, va[i]);
        check({name, ".dsp_b"}, m_dsp_b, vb[i]);
        check({name, ".load_acc"}, m_load, (i != 0));
      end
      if (i == bub_at && i < n - 1) bubbles(nbub);
    end
    wait_valid(sel, lat);
    check({name, ".latency"}, lat, 2);
    check({name, ".out_data"}, (sel == 0) ? m_out_data : s_out_data, exp_data);
    check({name, ".out_len"}, (sel == 0) ? 32'(m_out_len) : 32'(s_out_len), exp_len);
    check({name, ".out_trunc"}, (sel == 0) ? m_out_trunc : s_out_trunc, exp_trunc);
    if (sel == 0) begin
      check({name, ".dsp_unsigned_a"}, m_ua, ua);
      check({name, ".dsp_unsigned_b"}, m_ub, ub);
      check({name, ".dsp_subtract"}, m_sub, sub);
      check({name, ".in_ready_hold"}, m_in_ready, 0);
    end
    @(posedge clk); #1;
    check({name, ".out_valid_drop"}, (sel == 0) ? m_out_valid : s_out_valid, 0);
  endtask

  typedef struct packed {
    logic [3:0][19:0] a;
    logic [3:0][17:0] b;
    logic [2:0]       n;
    logic             ua, ub, sub;
    logic [1:0]       bub_at;
    logic [1:0]       nbub;
    logic [37:0]      exp_data;
  } vec_t;

  vec_t tbl [6];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int          lat;
    int          n, bub_at, nbub;
    logic        ua, ub, sub;

    // {a3,a2,a1,a0}, {b3,b2,b1,b0}; expectations worked out by hand.
    tbl[0] = '{a: {20'd0, 20'hFFFFE, 20'd5, 20'd3}, b: {18'd0, 18'd7, 18'd6, 18'd4}, n: 3'd3,
               ua: 1'b0, ub: 1'b0, sub: 1'b0, bub_at: 2'd3, nbub: 2'd0, exp_data: 38'd28};
    tbl[1] = '{a: {60'd0, 20'hFFFFF}, b: {54'd0, 18'h3FFFF}, n: 3'd1,
               ua: 1'b1, ub: 1'b1, sub: 1'b0, bub_at: 2'd3, nbub: 2'd0, exp_data: 38'h3F_FFEC_0001};
    tbl[2] = '{a: {40'd0, 20'd1, 20'd2}, b: {36'd0, 18'd1, 18'd2}, n: 3'd2,
               ua: 1'b0, ub: 1'b0, sub: 1'b0, bub_at: 2'd0, nbub: 2'd3, exp_data: 38'd5};
    tbl[3] = '{a: {40'd0, 20'd2, 20'd10}, b: {36'd0, 18'd5, 18'd3}, n: 3'd2,
               ua: 1'b0, ub: 1'b0, sub: 1'b1, bub_at: 2'd3, nbub: 2'd0, exp_data: 38'h3F_FFFF_FFD8};
    tbl[4] = '{a: {60'd0, 20'hFFFFF}, b: {54'd0, 18'h3FFFF}, n: 3'd1,
               ua: 1'b0, ub: 1'b1, sub: 1'b0, bub_at: 2'd3, nbub: 2'd0, exp_data: 38'h3F_FFFC_0001};
    tbl[5] = '{a: {60'd0, 20'h80000}, b: {54'd0, 18'h20000}, n: 3'd1,
               ua: 1'b0, ub: 1'b0, sub: 1'b0, bub_at: 2'd3, nbub: 2'd0, exp_data: 38'h10_0000_0000};

    reset = 1'b1; m_in_valid = 1'b0; s_in_valid = 1'b0;
    in_a = '0; in_b = '0; in_last = 1'b0;
    cfg_ua = 1'b0; cfg_ub = 1'b0; cfg_sub = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset.in_ready", m_in_ready, 0);
    check("reset.dsp_a", m_dsp_a, 0);
    check("reset.load_acc", m_load, 0);
    check("reset.feedback", m_fb, 0);
    check("reset.out_valid", m_out_valid, 0);
    check("reset.out_data", m_out_data, 0);
    check("reset.out_len", m_out_len, 0);
    check("reset.out_trunc", m_out_trunc, 0);
    check("reset.dsp_unsigned_a", m_ua, 0);
    reset = 1'b0;
    #1;
    check("idle.in_ready", m_in_ready, 1);

    // Table-driven directed vectors.
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 4; i++) begin
        va[i] = tbl[t].a[i];
        vb[i] = tbl[t].b[i];
      end
      run_vec(0, int'(tbl[t].n), 1'b1, tbl[t].ua, tbl[t].ub, tbl[t].sub,
              int'(tbl[t].bub_at), int'(tbl[t].nbub), tbl[t].exp_data, int'(tbl[t].n), 1'b0, "tbl");
    end
    check("feedback", m_fb, 0);

    // Randomized vectors against the dot-product reference.
    for (int v = 0; v < 20; v++) begin
      n      = int'($urandom_range(1, 8));
      ua     = 1'($urandom);
      ub     = 1'($urandom);
      sub    = 1'($urandom);
      bub_at = int'($urandom_range(0, 7));
      nbub   = int'($urandom_range(0, 3));
      for (int i = 0; i < n; i++) begin
        va[i] = 20'($urandom);
        vb[i] = 18'($urandom);
      end
      run_vec(0, n, 1'b1, ua, ub, sub, bub_at, nbub, ref_dot(n, ua, ub, sub), n, 1'b0, "rand");
    end

    // MAX_LEN=4 instance: force-close, a short vector, and exactly-at-cap with last.
    for (int i = 0; i < 4; i++) begin
      va[i] = 20'd1;
      vb[i] = 18'd1;
    end
    run_vec(1, 4, 1'b0, 1'b0, 1'b0, 1'b0, 9, 0, 38'd4, 4, 1'b1, "cap_trunc");
    run_vec(1, 2, 1'b1, 1'b0, 1'b0, 1'b0, 9, 0, 38'd2, 2, 1'b0, "cap_second");
    run_vec(1, 4, 1'b1, 1'b0, 1'b0, 1'b0, 9, 0, 38'd4, 4, 1'b0, "cap_exact");

    // Full-length force-close on the default instance.
    for (int i = 0; i < 1024; i++) send_beat(0, 20'd1, 18'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_valid(0, lat);
    check("max.latency", lat, 2);
    check("max.out_data", m_out_data, 38'd1024);
    check("max.out_len", m_out_len, 1024);
    check("max.out_trunc", m_out_trunc, 1);
    @(posedge clk); #1;

    // Result held under backpressure while a new beat waits.
    out_ready = 1'b0;
    send_beat(0, 20'd9, 18'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    wait_valid(0, lat);
    check("stall.latency", lat, 2);
    in_a = 20'd7; in_b = 18'd3; in_last = 1'b1; m_in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall.in_ready", m_in_ready, 0);
      check("stall.out_valid", m_out_valid, 1);
      check("stall.out_data", m_out_data, 38'd81);
      @(posedge clk);
    end
    #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("release.out_valid", m_out_valid, 0);
    check("release.in_ready", m_in_ready, 1);
    @(posedge clk); #1;
    m_in_valid = 1'b0;
    check("release.dsp_a", m_dsp_a, 7);
    check("release.in_ready_drain", m_in_ready, 0);
    wait_valid(0, lat);
    check("release.latency", lat, 2);
    check("release.out_data", m_out_data, 38'd21);
    @(posedge clk); #1;

    // Reset in the middle of accumulation.
    send_beat(0, 20'd5, 18'd5, 1'b0, 1'b1, 1'b0, 1'b0);
    send_beat(0, 20'd6, 18'd6, 1'b0, 1'b1, 1'b0, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    check("rst_accum.dsp_a", m_dsp_a, 0);
    check("rst_accum.load_acc", m_load, 0);
    check("rst_accum.in_ready", m_in_ready, 0);
    check("rst_accum.out_len", m_out_len, 0);
    check("rst_accum.dsp_unsigned_a", m_ua, 0);
    reset = 1'b0;
    va[0] = 20'd7; vb[0] = 18'd7;
    run_vec(0, 1, 1'b1, 1'b0, 1'b0, 1'b0, 9, 0, 38'd49, 1, 1'b0, "rst_fresh");

    // Reset while a result is held discards it.
    out_ready = 1'b0;
    send_beat(0, 20'd3, 18'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    wait_valid(0, lat);
    check("rst_hold.out_data_before", m_out_data, 38'd9);
    reset = 1'b1;
    @(posedge clk); #1;
    check("rst_hold.out_valid", m_out_valid, 0);
    check("rst_hold.out_data", m_out_data, 0);
    reset = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
